// File: rtl/cmd_rd53_pkg.sv
// Shared RD53 command-stream constants: sync/tag symbols, trigger code table, frame types.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cmd_rd53_pkg;

   localparam logic [15:0] SYNC_PATTERN = 16'h817E;
   localparam logic [7:0]  TAG_PATTERN  = 8'h6A;

   // Trigger codes in index order: entry 0 is trigger index 1.
   localparam int TRIG_CODES_N = 15;
   localparam logic [7:0] TRIG_CODES [TRIG_CODES_N] = '{
      8'h2B, 8'h2D, 8'h2E, 8'h33, 8'h35, 8'h36, 8'h39, 8'h3A,
      8'h3C, 8'h4B, 8'h4D, 8'h4E, 8'h53, 8'h55, 8'h56
   };

   typedef enum logic [1:0] {
      FT_DATA = 2'd0,
      FT_SYNC = 2'd1,
      FT_TRIG = 2'd2,
      FT_ERR  = 2'd3
   } frame_type_e;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } dec_state_e;

endpackage

// File: rtl/cmd_rd53_trig_lut.sv
// Maps an 8-bit trigger code to its 4-bit trigger index (0 = not a trigger code).
// Latency: combinational.
// Backpressure: none.
module cmd_rd53_trig_lut
   import cmd_rd53_pkg::*;
(
   input  logic [7:0] code,
   output logic [3:0] index
);

   // Table search; codes are unique so at most one entry matches.
   always_comb begin
      index = 4'd0;
      for (int i = 0; i < TRIG_CODES_N; i++) begin
         if (code == TRIG_CODES[i]) begin
            index = 4'(i + 1);
         end
      end
   end

endmodule

// File: rtl/cmd_rd53_frame_decoder.sv
// RD53 command-stream monitor: deserialize, lock on sync, classify and count frames.
// Latency: frame outputs registered one cycle after the boundary (17 cycles after first bit).
// Backpressure: none; one frame per 16 cycles, outputs are strobes.
module cmd_rd53_frame_decoder
   import cmd_rd53_pkg::*;
#(
   parameter int LOCK_SYNCS  = 4,
   parameter int UNLOCK_ERRS = 4,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 CMD_CLK,
   input  logic                 RST,
   input  logic                 CMD_EN,
   input  logic                 CMD_SERIAL_IN,
   input  logic                 CNT_CLR,
   output logic                 LOCKED,
   output logic                 FRAME_VALID,
   output logic [15:0]          FRAME_DATA,
   output logic [1:0]           FRAME_TYPE,
   output logic [3:0]           TRIG_INDEX,
   output logic [CNT_WIDTH-1:0] DATA_CNT,
   output logic [CNT_WIDTH-1:0] TRIG_CNT,
   output logic [CNT_WIDTH-1:0] ERR_CNT
);

   localparam logic [3:0] LOCK_SYNCS_L  = 4'(LOCK_SYNCS);
   localparam logic [3:0] UNLOCK_ERRS_L = 4'(UNLOCK_ERRS);

   logic [15:0]  sr;
   logic [3:0]   bit_cnt, bit_cnt_nxt;
   logic [3:0]   sync_run, sync_run_nxt;
   logic [3:0]   err_run, err_run_nxt;
   dec_state_e   state, state_nxt;
   logic         report;
   logic         boundary;
   logic [3:0]   lut_idx;
   frame_type_e  ftype;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   endfunction

   cmd_rd53_trig_lut u_trig_lut (
      .code  (sr[15:8]),
      .index (lut_idx)
   );

   assign boundary = CMD_EN && (bit_cnt == 4'd15);
   assign LOCKED   = (state == ST_LOCKED);

   // Classify the frame currently held in the shift register.
   always_comb begin
      ftype = FT_DATA;
      if (sr == SYNC_PATTERN) begin
         ftype = FT_SYNC;
      end else if ((sr[7:0] == TAG_PATTERN) && (lut_idx != 4'd0)) begin
         ftype = FT_TRIG;
      end else if ((sr[15:8] == SYNC_PATTERN[15:8]) != (sr[7:0] == SYNC_PATTERN[7:0])) begin
         ftype = FT_ERR;
      end
   end

   // Alignment FSM: next state, run counters, bit counter and report strobe.
   always_comb begin
      state_nxt    = state;
      sync_run_nxt = sync_run;
      err_run_nxt  = err_run;
      bit_cnt_nxt  = CMD_EN ? bit_cnt + 4'd1 : bit_cnt;
      report       = 1'b0;
      if (!CMD_EN) begin
         state_nxt    = ST_HUNT;
         sync_run_nxt = 4'd0;
         err_run_nxt  = 4'd0;
      end else begin
         case (state)
            ST_HUNT: begin
               // Match lands on the sync's last bit; next boundary is 16 cycles out.
               if (sr == SYNC_PATTERN) begin
                  bit_cnt_nxt  = 4'd0;
                  sync_run_nxt = 4'd1;
                  state_nxt    = ST_VERIFY;
               end
            end
            ST_VERIFY: begin
               if (boundary) begin
                  if (ftype == FT_SYNC) begin
                     sync_run_nxt = sync_run + 4'd1;
                     if (sync_run + 4'd1 >= LOCK_SYNCS_L) begin
                        state_nxt   = ST_LOCKED;
                        err_run_nxt = 4'd0;
                        report      = 1'b1;
                     end
                  end else begin
                     state_nxt    = ST_HUNT;
                     sync_run_nxt = 4'd0;
                  end
               end
            end
            ST_LOCKED: begin
               if (boundary) begin
                  report = 1'b1;
                  if (ftype == FT_ERR) begin
                     err_run_nxt = err_run + 4'd1;
                     if (err_run + 4'd1 >= UNLOCK_ERRS_L) begin
                        state_nxt    = ST_HUNT;
                        err_run_nxt  = 4'd0;
                        sync_run_nxt = 4'd0;
                     end
                  end else begin
                     err_run_nxt = 4'd0;
                  end
               end
            end
            default: begin
               state_nxt = ST_HUNT;
            end
         endcase
      end
   end

   // State, shift register and run counters.
   always_ff @(posedge CMD_CLK) begin
      if (RST) begin
         state    <= ST_HUNT;
         sr       <= 16'h0000;
         bit_cnt  <= 4'd0;
         sync_run <= 4'd0;
         err_run  <= 4'd0;
      end else begin
         state    <= state_nxt;
         bit_cnt  <= bit_cnt_nxt;
         sync_run <= sync_run_nxt;
         err_run  <= err_run_nxt;
         if (CMD_EN) begin
            sr <= {sr[14:0], CMD_SERIAL_IN};
         end
      end
   end

   // Registered frame report; data/type/index hold between reports.
   always_ff @(posedge CMD_CLK) begin
      if (RST) begin
         FRAME_VALID <= 1'b0;
         FRAME_DATA  <= 16'h0000;
         FRAME_TYPE  <= 2'd0;
         TRIG_INDEX  <= 4'd0;
      end else begin
         FRAME_VALID <= report;
         if (report) begin
            FRAME_DATA <= sr;
            FRAME_TYPE <= ftype;
            TRIG_INDEX <= (ftype == FT_TRIG) ? lut_idx : 4'd0;
         end
      end
   end

   // Saturating per-type counters; a clear beats a same-cycle increment.
   always_ff @(posedge CMD_CLK) begin
      if (RST || CNT_CLR) begin
         DATA_CNT <= '0;
         TRIG_CNT <= '0;
         ERR_CNT  <= '0;
      end else if (report) begin
         case (ftype)
            FT_DATA: DATA_CNT <= sat_inc(DATA_CNT);
            FT_TRIG: TRIG_CNT <= sat_inc(TRIG_CNT);
            FT_ERR:  ERR_CNT  <= sat_inc(ERR_CNT);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_rd53_frame_decoder.sv
// Directed bench for cmd_rd53_frame_decoder with a queue-based frame scoreboard.
// A second instance with 2-bit counters exercises counter saturation.
// Serial stimulus driven on the falling edge; reports sampled 1 time unit after the rising edge.
module tb_cmd_rd53_frame_decoder;

   logic        CMD_CLK = 1'b0;
   logic        RST, CMD_EN, CMD_SERIAL_IN, CNT_CLR;
   logic        LOCKED, FRAME_VALID;
   logic [15:0] FRAME_DATA;
   logic [1:0]  FRAME_TYPE;
   logic [3:0]  TRIG_INDEX;
   logic [15:0] DATA_CNT, TRIG_CNT, ERR_CNT;

   logic        s_locked, s_valid;
   logic [15:0] s_data;
   logic [1:0]  s_type;
   logic [3:0]  s_idx;
   logic [1:0]  s_data_cnt, s_trig_cnt, s_err_cnt;

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  ftype;
      logic [3:0]  idx;
      logic        locked;
   } rpt_t;

   rpt_t exp_q[$];
   rpt_t mon_got, mon_exp;
   int   n_vec  = 0;
   int   n_miss = 0;
   int   clr_slot = -1;

   always #5 CMD_CLK = ~CMD_CLK;

   cmd_rd53_frame_decoder dut (
      .CMD_CLK(CMD_CLK), .RST(RST), .CMD_EN(CMD_EN), .CMD_SERIAL_IN(CMD_SERIAL_IN),
      .CNT_CLR(CNT_CLR), .LOCKED(LOCKED), .FRAME_VALID(FRAME_VALID),
      .FRAME_DATA(FRAME_DATA), .FRAME_TYPE(FRAME_TYPE), .TRIG_INDEX(TRIG_INDEX),
      .DATA_CNT(DATA_CNT), .TRIG_CNT(TRIG_CNT), .ERR_CNT(ERR_CNT)
   );

   cmd_rd53_frame_decoder #(.CNT_WIDTH(2)) dut_sat (
      .CMD_CLK(CMD_CLK), .RST(RST), .CMD_EN(CMD_EN), .CMD_SERIAL_IN(CMD_SERIAL_IN),
      .CNT_CLR(CNT_CLR), .LOCKED(s_locked), .FRAME_VALID(s_valid),
      .FRAME_DATA(s_data), .FRAME_TYPE(s_type), .TRIG_INDEX(s_idx),
      .DATA_CNT(s_data_cnt), .TRIG_CNT(s_trig_cnt), .ERR_CNT(s_err_cnt)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Drive the top n bits of w, MSB first; CNT_CLR pulses on bit position clr_slot.
   task automatic send_bits(input logic [15:0] w, input int n);
      for (int i = 15; i > 15 - n; i--) begin
         @(negedge CMD_CLK);
         CMD_SERIAL_IN = w[i];
         CNT_CLR       = (i == clr_slot);
      end
   endtask

   task automatic send_frame(input logic [15:0] w, input bit rpt, input logic [1:0] t,
                             input logic [3:0] idx, input logic lk);
      if (rpt) exp_q.push_back('{data: w, ftype: t, idx: idx, locked: lk});
      send_bits(w, 16);
   endtask

   task automatic pad_sync();
      send_frame(16'h817E, 1'b1, 2'd1, 4'd0, 1'b1);
   endtask

   // Scoreboard monitor: every reported frame must match the next expected entry.
   always @(posedge CMD_CLK) begin
      #1;
      if (FRAME_VALID === 1'b1) begin
         mon_got = '{data: FRAME_DATA, ftype: FRAME_TYPE, idx: TRIG_INDEX, locked: LOCKED};
         n_vec++;
         if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL unexpected_frame: got data=%h type=%0d idx=%0d locked=%0b, expected no frame",
                     mon_got.data, mon_got.ftype, mon_got.idx, mon_got.locked);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               n_miss++;
               $display("FAIL frame_report: got data=%h type=%0d idx=%0d locked=%0b, expected data=%h type=%0d idx=%0d locked=%0b",
                        mon_got.data, mon_got.ftype, mon_got.idx, mon_got.locked,
                        mon_exp.data, mon_exp.ftype, mon_exp.idx, mon_exp.locked);
            end
         end
      end
   end

   initial begin
      RST = 1'b1; CMD_EN = 1'b0; CMD_SERIAL_IN = 1'b0; CNT_CLR = 1'b0;
      repeat (3) @(negedge CMD_CLK);
      check("rst_locked", 32'(LOCKED), 32'h0);
      check("rst_valid",  32'(FRAME_VALID), 32'h0);
      check("rst_data",   32'(FRAME_DATA), 32'h0);
      check("rst_type",   32'(FRAME_TYPE), 32'h0);
      check("rst_index",  32'(TRIG_INDEX), 32'h0);
      check("rst_data_cnt", 32'(DATA_CNT), 32'h0);
      check("rst_trig_cnt", 32'(TRIG_CNT), 32'h0);
      check("rst_err_cnt",  32'(ERR_CNT), 32'h0);
      @(negedge CMD_CLK);
      RST = 1'b0; CMD_EN = 1'b1;

      // Acquisition at a 5-bit offset: the 4th sync locks and is reported.
      send_bits(16'h0000, 5);
      for (int k = 0; k < 3; k++) send_frame(16'h817E, 1'b0, 2'd0, 4'd0, 1'b0);
      for (int k = 0; k < 3; k++) pad_sync();
      check("acq_locked", 32'(LOCKED), 32'h1);

      // Trigger frame with index 2.
      send_frame(16'h2D6A, 1'b1, 2'd2, 4'd2, 1'b1);
      pad_sync();
      check("trig_cnt_1", 32'(TRIG_CNT), 32'h1);

      // Two data frames.
      send_frame(16'h1234, 1'b1, 2'd0, 4'd0, 1'b1);
      send_frame(16'hA5A5, 1'b1, 2'd0, 4'd0, 1'b1);
      pad_sync();
      check("data_cnt_2", 32'(DATA_CNT), 32'h2);

      // Error runs broken by data frames keep lock.
      for (int k = 0; k < 3; k++) send_frame(16'h8100, 1'b1, 2'd3, 4'd0, 1'b1);
      send_frame(16'h0000, 1'b1, 2'd0, 4'd0, 1'b1);
      for (int k = 0; k < 3; k++) send_frame(16'h8100, 1'b1, 2'd3, 4'd0, 1'b1);
      send_frame(16'h0000, 1'b1, 2'd0, 4'd0, 1'b1);
      check("err_run3_locked", 32'(LOCKED), 32'h1);

      // Four consecutive errors: the 4th is reported with LOCKED already low.
      for (int k = 0; k < 3; k++) send_frame(16'h8100, 1'b1, 2'd3, 4'd0, 1'b1);
      send_frame(16'h8100, 1'b1, 2'd3, 4'd0, 1'b0);
      send_frame(16'h817E, 1'b0, 2'd0, 4'd0, 1'b0);
      check("unlock_locked", 32'(LOCKED), 32'h0);
      check("err_cnt_10",    32'(ERR_CNT), 32'd10);
      check("data_cnt_4",    32'(DATA_CNT), 32'd4);
      for (int k = 0; k < 2; k++) send_frame(16'h817E, 1'b0, 2'd0, 4'd0, 1'b0);
      pad_sync();

      // Mid-frame enable drop: lock lost next cycle, reacquired, counters kept.
      send_bits(16'h0000, 7);
      @(negedge CMD_CLK);
      CMD_EN = 1'b0;
      @(negedge CMD_CLK);
      check("en_drop_locked", 32'(LOCKED), 32'h0);
      repeat (3) @(negedge CMD_CLK);
      @(negedge CMD_CLK);
      CMD_EN = 1'b1; CMD_SERIAL_IN = 1'b0;
      send_bits(16'h0000, 8);
      for (int k = 0; k < 3; k++) send_frame(16'h817E, 1'b0, 2'd0, 4'd0, 1'b0);
      pad_sync();
      pad_sync();
      check("reacq_locked",   32'(LOCKED), 32'h1);
      check("kept_data_cnt",  32'(DATA_CNT), 32'd4);
      check("kept_trig_cnt",  32'(TRIG_CNT), 32'd1);
      check("kept_err_cnt",   32'(ERR_CNT), 32'd10);

      // Saturation on the 2-bit instance; clear coinciding with an increment.
      clr_slot = 8;
      send_frame(16'h1111, 1'b1, 2'd0, 4'd0, 1'b1);
      clr_slot = -1;
      send_frame(16'h1111, 1'b1, 2'd0, 4'd0, 1'b1);
      send_frame(16'h1111, 1'b1, 2'd0, 4'd0, 1'b1);
      pad_sync();
      check("sat_main_3",  32'(DATA_CNT), 32'd3);
      check("sat_small_3", 32'(s_data_cnt), 32'd3);
      send_frame(16'h1111, 1'b1, 2'd0, 4'd0, 1'b1);
      pad_sync();
      check("sat_main_4",    32'(DATA_CNT), 32'd4);
      check("sat_small_hold", 32'(s_data_cnt), 32'd3);
      check("sat_small_err",  32'(s_err_cnt), 32'd0);
      send_frame(16'h0F0F, 1'b1, 2'd0, 4'd0, 1'b1);
      clr_slot = 15;
      send_frame(16'h0000, 1'b1, 2'd0, 4'd0, 1'b1);
      clr_slot = -1;
      pad_sync();
      check("clr_wins_main",  32'(DATA_CNT), 32'd1);
      check("clr_wins_small", 32'(s_data_cnt), 32'd1);
      check("clr_trig_cnt",   32'(TRIG_CNT), 32'd0);

      // Let the last report land, then stop the stream.
      @(negedge CMD_CLK);
      CMD_SERIAL_IN = 1'b0;
      @(negedge CMD_CLK);
      CMD_EN = 1'b0;
      repeat (20) @(negedge CMD_CLK);
      check("small_last_data", 32'(s_data), 32'h817E);
      check("small_last_type", 32'(s_type), 32'd1);
      check("small_last_idx",  32'(s_idx), 32'd0);
      check("small_valid_idle", 32'(s_valid), 32'd0);
      check("small_unlocked",  32'(s_locked), 32'd0);
      check("small_trig_cnt",  32'(s_trig_cnt), 32'd0);
      check("queue_drained",   32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
